// File: rtl/aui_lane_am_lock.sv
// aui_lane_am_lock: per-lane alignment-marker search/verify/lock with one-cycle registered pass-through
module aui_lane_am_lock #(
  parameter int LANE_WIDTH = 1360,
  parameter int AM_BITS    = 120,
  parameter int AM_PERIOD  = 8192,
  parameter int MAX_BAD_AM = 3,
  parameter int CNT_W      = $clog2(AM_PERIOD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [LANE_WIDTH-1:0] i_data,
  input  logic [AM_BITS-1:0]    i_am_pattern,
  output logic                  o_valid,
  output logic [LANE_WIDTH-1:0] o_data,
  output logic                  o_am,
  output logic                  o_lock,
  output logic                  o_lock_loss,
  output logic [15:0]           o_am_err_cnt
);
  localparam int BAD_W = $clog2(MAX_BAD_AM + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [BAD_W-1:0] LAST_BAD = BAD_W'(MAX_BAD_AM - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] word_cnt, cnt_n;
  logic [BAD_W-1:0] bad_cnt, bad_n;
  logic             match, expected, am_n, loss_n, miss;

  // next-state, counters and per-word tags for the word currently at the input
  always_comb begin
    match    = i_data[AM_BITS-1:0] == i_am_pattern;
    expected = i_valid && word_cnt == LAST;
    state_n  = state;
    cnt_n    = i_valid ? ((word_cnt == LAST) ? '0 : word_cnt + 1'b1) : word_cnt;
    bad_n    = bad_cnt;
    am_n     = 1'b0;
    loss_n   = 1'b0;
    miss     = 1'b0;
    case (state)
      SEARCH: if (i_valid && match) begin
        state_n = VERIFY;
        cnt_n   = '0;
      end
      VERIFY: if (expected) begin
        state_n = match ? LOCKED : SEARCH;
        am_n    = match;
        bad_n   = '0;
      end
      LOCKED: if (expected) begin
        am_n = 1'b1;
        miss = !match;
        if (match) bad_n = '0;
        else if (bad_cnt == LAST_BAD) begin
          state_n = SEARCH;
          bad_n   = '0;
          loss_n  = 1'b1;
        end else bad_n = bad_cnt + 1'b1;
      end
      default: state_n = SEARCH;
    endcase
  end

  // state registers and outputs aligned with the word moving to o_data
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SEARCH;
      word_cnt     <= '0;
      bad_cnt      <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_am         <= 1'b0;
      o_lock       <= 1'b0;
      o_lock_loss  <= 1'b0;
      o_am_err_cnt <= '0;
    end else begin
      state        <= state_n;
      word_cnt     <= cnt_n;
      bad_cnt      <= bad_n;
      o_valid      <= i_valid;
      o_data       <= i_data;
      o_am         <= am_n;
      o_lock       <= state_n == LOCKED;
      o_lock_loss  <= loss_n;
      if (miss && o_am_err_cnt != 16'hFFFF) o_am_err_cnt <= o_am_err_cnt + 16'd1;
    end
  end
endmodule
